padder_ctrl: RTL and testbench

- Sequential front end of the low-throughput SHA-3 core.
- Collects 32-bit message words into one rate-sized block and applies the FIPS 202 pad10*1 rule.
- Domain byte 0x06 follows the last message byte; 0x80 is ORed into the final byte of the block.
- Presents each full block to the permutation with a ready/ack handshake; after the padded block is acknowledged, returns to idle for the next message.

---
 rtl/padder_ctrl_if.sv | 25 ++
 rtl/padder_ctrl.sv | 127 ++++++++++++
 tb/tb_padder_ctrl.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/padder_ctrl_if.sv
// Message-in / block-out handshake bundle between a word source, the
// padder and the permutation.
interface padder_ctrl_if #(
   parameter int RATE_WORDS = 18
);
   logic [31:0]              in;
   logic                     in_ready;
   logic                     is_last;
   logic [1:0]               byte_num;
   logic                     buffer_full;
   logic [RATE_WORDS*32-1:0] out;
   logic                     out_ready;
   logic                     f_ack;
   logic                     padded;

   modport master (
      output in, in_ready, is_last, byte_num, f_ack,
      input  buffer_full, out, out_ready, padded
   );

   modport slave (
      input  in, in_ready, is_last, byte_num, f_ack,
      output buffer_full, out, out_ready, padded
   );
endinterface

// File: rtl/padder_ctrl.sv
// SHA-3 front end: packs 32-bit message words into one rate block, applies
// pad10*1 with the domain byte, and hands full blocks over with ready/ack.
module padder_ctrl #(
   parameter int          RATE_WORDS = 18,
   parameter logic [7:0]  DOMAIN     = 8'h06
) (
   input  logic         clk,
   input  logic         reset,
   padder_ctrl_if.slave bus
);
   localparam int         W         = RATE_WORDS * 32;
   localparam logic [4:0] LAST_SLOT = 5'(RATE_WORDS - 1);

   typedef enum logic [1:0] {
      ACCEPT    = 2'd0,
      PAD       = 2'd1,
      FULL      = 2'd2,
      FULL_LAST = 2'd3
   } state_t;

   state_t         state_r, state_s;
   logic [4:0]     cnt_r, cnt_s;
   logic           padded_r, padded_s;
   logic           out_ready_r;
   logic [W-1:0]   out_r;
   logic [31:0]    word_s;
   logic           shift_s;
   logic           final_slot_s;

   // Final message word: keep the valid bytes, append the domain byte, and
   // close the block with 0x80 when this word also occupies the last slot.
   function automatic logic [31:0] tail_word(input logic [31:0] data,
                                             input logic [1:0]  nbytes,
                                             input logic        final_slot);
      logic [31:0] w;
      case (nbytes)
         2'd0:    w = {DOMAIN, 24'h000000};
         2'd1:    w = {data[31:24], DOMAIN, 16'h0000};
         2'd2:    w = {data[31:16], DOMAIN, 8'h00};
         2'd3:    w = {data[31:8], DOMAIN};
         default: w = {DOMAIN, 24'h000000};
      endcase
      w[7:0] = final_slot ? (w[7:0] | 8'h80) : w[7:0];
      return w;
   endfunction

   assign final_slot_s = (cnt_r == LAST_SLOT);

   // Next-state, counter and shift-word selection.
   always_comb begin
      state_s  = state_r;
      cnt_s    = cnt_r;
      padded_s = 1'b0;
      shift_s  = 1'b0;
      word_s   = 32'h00000000;
      case (state_r)
         ACCEPT: begin
            if (bus.in_ready) begin
               shift_s = 1'b1;
               if (bus.is_last) begin
                  word_s = tail_word(bus.in, bus.byte_num, final_slot_s);
               end else begin
                  word_s = bus.in;
               end
               // The counter saturates on the last slot; only f_ack rewinds it.
               if (final_slot_s) begin
                  state_s = bus.is_last ? FULL_LAST : FULL;
               end else begin
                  cnt_s   = cnt_r + 5'd1;
                  state_s = bus.is_last ? PAD : ACCEPT;
               end
            end else begin
               shift_s = 1'b0;
            end
         end
         PAD: begin
            shift_s = 1'b1;
            if (final_slot_s) begin
               word_s  = 32'h00000080;
               state_s = FULL_LAST;
            end else begin
               word_s  = 32'h00000000;
               cnt_s   = cnt_r + 5'd1;
            end
         end
         FULL, FULL_LAST: begin
            if (bus.f_ack) begin
               cnt_s    = 5'd0;
               state_s  = ACCEPT;
               padded_s = (state_r == FULL_LAST);
            end else begin
               state_s  = state_r;
            end
         end
         default: begin
            state_s = ACCEPT;
            cnt_s   = 5'd0;
         end
      endcase
   end

   // State, counter, block shift register and registered handshake outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r     <= ACCEPT;
         cnt_r       <= 5'd0;
         padded_r    <= 1'b0;
         out_ready_r <= 1'b0;
         out_r       <= {W{1'b0}};
      end else begin
         state_r     <= state_s;
         cnt_r       <= cnt_s;
         padded_r    <= padded_s;
         out_ready_r <= (state_s == FULL) || (state_s == FULL_LAST);
         if (shift_s) begin
            out_r <= {out_r[W-33:0], word_s};
         end else begin
            out_r <= out_r;
         end
      end
   end

   assign bus.buffer_full = (state_r != ACCEPT);
   assign bus.out         = out_r;
   assign bus.out_ready   = out_ready_r;
   assign bus.padded      = padded_r;
endmodule

// File: tb/tb_padder_ctrl.sv
// Scoreboard bench for padder_ctrl: a byte-level pad10*1 model predicts every
// block; a consumer process compares blocks as they appear and acknowledges.
module tb_padder_ctrl;
   localparam int RW = 18;
   localparam int W  = RW * 32;
   localparam int RB = RW * 4;

   typedef struct {
      logic [W-1:0] blk;
      bit           last;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   padder_ctrl_if #(.RATE_WORDS(RW)) bif ();
   padder_ctrl #(.RATE_WORDS(RW), .DOMAIN(8'h06)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bif)
   );

   exp_t        sb[$];
   logic [31:0] msg_q[$];
   int          total = 0;
   int          bad = 0;
   int          ack_delay = 2;

   task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Byte stream model: message || tail || 0x06 || 0.. with 0x80 in the last byte.
   task automatic model_msg(input int nb, input logic [31:0] tail);
      logic [7:0]   bq[$];
      logic [W-1:0] b;
      exp_t         e;
      int           nblk;
      foreach (msg_q[i])
         for (int k = 0; k < 4; k++) bq.push_back(msg_q[i][31-8*k -: 8]);
      for (int k = 0; k < nb; k++) bq.push_back(tail[31-8*k -: 8]);
      bq.push_back(8'h06);
      while (bq.size() % RB != 0) bq.push_back(8'h00);
      bq[bq.size()-1] = bq[bq.size()-1] | 8'h80;
      nblk = bq.size() / RB;
      for (int k = 0; k < nblk; k++) begin
         b = '0;
         for (int j = 0; j < RB; j++) b = {b[W-9:0], bq[k*RB+j]};
         e.blk  = b;
         e.last = (k == nblk - 1);
         sb.push_back(e);
      end
   endtask

   task automatic put_word(input logic [31:0] w, input logic last, input logic [1:0] nb);
      int t;
      t = 0;
      bif.in       = w;
      bif.in_ready = 1'b1;
      bif.is_last  = last;
      bif.byte_num = nb;
      while (bif.buffer_full !== 1'b0 && t < 300) begin
         @(negedge clk);
         t++;
      end
      if (t >= 300) check("accept_timeout", W'(bif.buffer_full), '0);
      @(negedge clk);
   endtask

   task automatic drop_input();
      bif.in_ready = 1'b0;
      bif.is_last  = 1'b0;
      bif.byte_num = 2'd0;
   endtask

   task automatic wait_idle();
      int t;
      t = 0;
      while ((sb.size() != 0 || bif.buffer_full !== 1'b0 || bif.f_ack) && t < 500) begin
         @(negedge clk);
         t++;
      end
      if (t >= 500) check("idle_timeout", W'(sb.size()), '0);
   endtask

   task automatic wait_ready(output int c);
      c = 1;
      while (bif.out_ready !== 1'b1 && c < 100) begin
         @(negedge clk);
         c++;
      end
   endtask

   // Consumer: compare each presented block while it is held, then acknowledge.
   initial begin
      exp_t e;
      bif.f_ack = 1'b0;
      forever begin
         @(negedge clk);
         if (reset === 1'b1 && bif.out_ready === 1'b1) begin
            if (sb.size() == 0) begin
               check("unexpected_block", W'(sb.size()), W'(1));
               e.blk  = '0;
               e.last = 1'b0;
            end else begin
               e = sb.pop_front();
            end
            for (int k = 0; k < ack_delay; k++) begin
               check("hold_out", bif.out, e.blk);
               check("hold_ready", W'(bif.out_ready), W'(1));
               @(negedge clk);
            end
            check("block", bif.out, e.blk);
            bif.f_ack = 1'b1;
            @(negedge clk);
            bif.f_ack = 1'b0;
            check("padded_pulse", W'(bif.padded), W'(e.last));
            check("ready_drop", W'(bif.out_ready), '0);
            check("accept_after_ack", W'(bif.buffer_full), '0);
         end
      end
   end

   initial begin
      #2ms;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int c;
      reset = 1'b0;
      bif.in = 32'h0;
      drop_input();
      repeat (3) @(negedge clk);
      check("rst_out_ready", W'(bif.out_ready), '0);
      check("rst_buffer_full", W'(bif.buffer_full), '0);
      check("rst_out", bif.out, '0);
      check("rst_padded", W'(bif.padded), '0);
      reset = 1'b1;
      @(negedge clk);

      // Empty message.
      msg_q = {};
      model_msg(0, 32'h0);
      put_word(32'hFFFFFFFF, 1'b1, 2'd0);
      drop_input();
      wait_ready(c);
      check("empty_latency", W'(c), W'(18));
      check("empty_first", bif.out[W-1 -: 32], W'(32'h06000000));
      check("empty_lsw", bif.out[31:0], W'(32'h00000080));
      wait_idle();

      // One-byte message, in_ready kept high through PAD.
      msg_q = {};
      model_msg(1, 32'h11223344);
      put_word(32'h11223344, 1'b1, 2'd1);
      bif.in      = 32'hDEADBEEF;
      bif.is_last = 1'b0;
      wait_ready(c);
      drop_input();
      check("onebyte_latency", W'(c), W'(18));
      wait_idle();

      // Tail in the final slot: no PAD cycles.
      msg_q = {};
      for (int i = 1; i <= 17; i++) msg_q.push_back(32'(i));
      model_msg(3, 32'hAABBCCDD);
      for (int i = 1; i <= 17; i++) put_word(32'(i), 1'b0, 2'd0);
      put_word(32'hAABBCCDD, 1'b1, 2'd3);
      drop_input();
      check("tail_ready_next", W'(bif.out_ready), W'(1));
      check("tail_lsw", bif.out[31:0], W'(32'hAABBCC86));
      wait_idle();

      // Multi-block with back-pressure toggling and a held 19th word.
      ack_delay = 10;
      msg_q = {};
      for (int i = 0; i < 18; i++) msg_q.push_back(32'hA0000000 + 32'(i));
      msg_q.push_back(32'h12345678);
      model_msg(2, 32'hBEEF0000);
      for (int i = 0; i < 18; i++) put_word(32'hA0000000 + 32'(i), 1'b0, 2'd0);
      bif.in_ready = 1'b0;
      wait_ready(c);
      check("full_latency", W'(c), W'(1));
      for (int k = 0; k < 8; k++) begin
         bif.in       = $urandom;
         bif.in_ready = 1'($urandom_range(0, 1));
         bif.is_last  = 1'($urandom_range(0, 1));
         bif.byte_num = 2'($urandom_range(0, 3));
         @(negedge clk);
      end
      put_word(32'h12345678, 1'b0, 2'd0);
      put_word(32'hBEEF0000, 1'b1, 2'd2);
      drop_input();
      wait_idle();

      // Reset in the middle of PAD.
      ack_delay = 2;
      msg_q = {};
      model_msg(0, 32'h0);
      put_word(32'h0, 1'b1, 2'd0);
      drop_input();
      repeat (4) @(negedge clk);
      reset = 1'b0;
      #1;
      check("midrst_out_ready", W'(bif.out_ready), '0);
      check("midrst_buffer_full", W'(bif.buffer_full), '0);
      check("midrst_out", bif.out, '0);
      sb.delete();
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      msg_q = {};
      model_msg(0, 32'h0);
      put_word(32'h55555555, 1'b1, 2'd0);
      drop_input();
      wait_ready(c);
      check("post_rst_latency", W'(c), W'(18));
      wait_idle();

      check("sb_empty", W'(sb.size()), '0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
